// File: rtl/spi_sub_rx_pkg.sv
// Shared SPI link definitions used by both ends of the 16-bit csb/sclk/mosi link.
// Holds the link mode, default word width and the receiver FSM encoding.
package spi_sub_rx_pkg;

  localparam int SPI_MODE           = 0;
  localparam int DEFAULT_WORD_WIDTH = 16;

  typedef enum logic [0:0] {
    SPI_IDLE  = 1'b0,
    SPI_SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sub_rx_sync_edge.sv
// N-flop synchroniser for one asynchronous pin, with a 1-flop history
// giving single-cycle rise/fall strobes on the synchronised value.
module sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [N-1:0] r_sync;
  logic         r_hist;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {N{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
      r_hist <= r_sync[N-1];
    end
  end

  assign o_q    = r_sync[N-1];
  assign o_rise = r_sync[N-1] & ~r_hist;
  assign o_fall = ~r_sync[N-1] & r_hist;

endmodule

// File: rtl/spi_sub_rx.sv
// SPI subordinate receiver: oversamples csb/sclk/mosi on clk, shifts words MSB first
// and presents each completed word on a valid/ack holding register.
module spi_sub_rx
  import spi_sub_rx_pkg::*;
#(
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  csb,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ack,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy,
  output spi_state_e            dbg_state
);

  localparam int             CW       = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WORD_WIDTH);

  spi_state_e             r_state, w_state_nxt;
  logic [CW-1:0]          r_bit_cnt;
  logic [WORD_WIDTH-1:0]  r_shift, r_word;
  logic                   r_valid, r_frame_err, r_overrun, r_armed;
  logic [SYNC_STAGES-1:0] r_mosi_sync, r_prime;

  logic w_unused_sclk_s, w_sclk_rise, w_sclk_fall, w_sample;
  logic w_csb_s, w_csb_rise, w_csb_fall, w_mosi_s;
  logic w_shift_en, w_frame_err, w_load, w_cnt_clr;

  sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_d    (sclk),
    .o_q    (w_unused_sclk_s),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_d    (csb),
    .o_q    (w_csb_s),
    .o_rise (w_csb_rise),
    .o_fall (w_csb_fall)
  );

  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_sample = (SPI_MODE == 0) ? w_sclk_rise : w_sclk_fall;
  // A full word waits one cycle in the shifter before moving to the holding register.
  assign w_load   = (r_bit_cnt == CNT_FULL);

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_frame_err = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      SPI_IDLE: begin
        w_cnt_clr = 1'b1;
        if (w_csb_fall && r_armed) w_state_nxt = SPI_SHIFT;
      end
      SPI_SHIFT: begin
        if (w_csb_rise) begin
          w_state_nxt = SPI_IDLE;
          w_cnt_clr   = 1'b1;
          w_frame_err = (r_bit_cnt != '0) && !w_load;
        end else if (w_sample) begin
          w_shift_en = 1'b1;
        end
      end
      default: w_state_nxt = SPI_IDLE;
    endcase
  end

  // r_prime marks when the csb synchroniser holds real pin samples rather than its
  // reset value; only a genuinely observed high csb arms the FSM for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SPI_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_word      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_armed     <= 1'b0;
      r_mosi_sync <= '0;
      r_prime     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_prime     <= {r_prime[SYNC_STAGES-2:0], 1'b1};
      if (r_prime[SYNC_STAGES-1] && w_csb_s) r_armed <= 1'b1;
      r_frame_err <= w_frame_err;
      r_overrun   <= 1'b0;

      if (w_cnt_clr || w_load) r_bit_cnt <= '0;
      else if (w_shift_en)     r_bit_cnt <= r_bit_cnt + CW'(1);

      if (w_shift_en) r_shift <= {r_shift[WORD_WIDTH-2:0], w_mosi_s};

      if (w_load) begin
        r_word    <= r_shift;
        r_valid   <= 1'b1;
        r_overrun <= r_valid & ~word_ack;
      end else if (r_valid && word_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = ~w_csb_s;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_spi_sub_rx.sv
// Bench for spi_sub_rx: directed link scenarios plus random frames, scored against
// a queue of words the host is known to have sent and counts of expected pulses.
module tb_spi_sub_rx;
  import spi_sub_rx_pkg::*;

  localparam int W    = 16;
  localparam int HALF = 5;

  logic         clk = 1'b0;
  logic         rst_n, sclk, mosi, csb;
  logic         force_ack, auto_ack_q, auto_mode;
  logic         word_ack;
  logic [W-1:0] word_out;
  logic         word_valid, frame_err, overrun, busy;
  spi_state_e   dbg_state;

  int checks = 0, failures = 0;
  int fe_cnt = 0, ov_cnt = 0, hs_cnt = 0, pushed = 0;
  int lat, fe_base, ov_base, exp_fe, nw, k;
  logic [W-1:0] exp_q[$];

  always #10 clk = ~clk;

  assign word_ack = force_ack | auto_ack_q;

  spi_sub_rx #(.WORD_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .csb       (csb),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ack  (word_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    csb = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    csb  = 1'b1;
    mosi = 1'b0;
    wait_clk(2 * HALF);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic send_word(input logic [W-1:0] val);
    exp_q.push_back(val);
    pushed++;
    send_bits(32'(val), W);
  endtask

  task automatic manual_ack(input string tag);
    force_ack = 1'b1;
    wait_clk(1);
    force_ack = 1'b0;
    check_eq(tag, 32'(word_valid), 0);
  endtask

  // Consumer model: acks each valid word 0..2 cycles after seeing it and scores it.
  initial begin
    auto_ack_q = 1'b0;
    forever begin
      @(negedge clk);
      auto_ack_q = 1'b0;
      if (auto_mode === 1'b1 && word_valid === 1'b1) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("sb_word", 32'(word_out), 32'(exp_q.pop_front()));
        hs_cnt++;
        auto_ack_q = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
  end

  initial begin
    rst_n = 1'b0; csb = 1'b1; sclk = 1'b0; mosi = 1'b0;
    force_ack = 1'b0; auto_mode = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    check_eq("rst_word_out", 32'(word_out), 0);
    check_eq("rst_valid", 32'(word_valid), 0);
    check_eq("rst_frame_err", 32'(frame_err), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_state", 32'(dbg_state), 32'(SPI_IDLE));
    wait_clk(2 * HALF);

    // Single word with latency measured from the last sclk rise.
    frame_start();
    check_eq("busy_in_frame", 32'(busy), 1);
    send_bits(32'hA5C3 >> 1, W - 1);
    mosi = 1'b1;
    wait_clk(HALF);
    sclk = 1'b1;
    lat  = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (word_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check_eq("latency", 32'(lat), 4);
    wait_clk(2);
    sclk = 1'b0;
    frame_end();
    check_eq("a5c3_word", 32'(word_out), 32'hA5C3);
    check_eq("a5c3_valid", 32'(word_valid), 1);
    check_eq("a5c3_no_fe", 32'(fe_cnt), 0);
    check_eq("a5c3_no_ov", 32'(ov_cnt), 0);
    manual_ack("a5c3_ack_clears");

    // Back-to-back words in one frame, acked by the consumer model.
    auto_mode = 1'b1;
    frame_start();
    send_word(16'h1234);
    send_word(16'hFFFF);
    frame_end();
    check_eq("b2b_q_empty", 32'(exp_q.size()), 0);
    check_eq("b2b_handshakes", 32'(hs_cnt), 32'(pushed));

    // Partial frame then a clean frame.
    frame_start();
    send_bits(32'h5555 >> 7, 9);
    frame_end();
    check_eq("partial_fe_once", 32'(fe_cnt), 1);
    check_eq("partial_no_valid", 32'(word_valid), 0);
    frame_start();
    send_word(16'h00FF);
    frame_end();
    check_eq("after_err_q_empty", 32'(exp_q.size()), 0);
    check_eq("after_err_handshakes", 32'(hs_cnt), 32'(pushed));
    wait_clk(2 * HALF);

    // Overrun: first word left unacked.
    auto_mode = 1'b0;
    frame_start();
    send_bits(32'h0001, W);
    frame_end();
    check_eq("ovr_first_valid", 32'(word_valid), 1);
    ov_base = ov_cnt;
    frame_start();
    send_bits(32'h0002, W);
    frame_end();
    check_eq("ovr_pulse_once", 32'(ov_cnt - ov_base), 1);
    check_eq("ovr_latest_wins", 32'(word_out), 32'h0002);
    check_eq("ovr_valid_held", 32'(word_valid), 1);

    // Ack lands in the exact cycle 0xBEEF is loaded while 0x0002 is still valid.
    ov_base = ov_cnt;
    frame_start();
    send_bits(32'hBEEF >> 1, W - 1);
    mosi = 1'b1;
    wait_clk(HALF);
    sclk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    check_eq("sim_ack_valid", 32'(word_valid), 1);
    check_eq("sim_ack_word", 32'(word_out), 32'hBEEF);
    wait_clk(HALF);
    sclk = 1'b0;
    frame_end();
    check_eq("sim_ack_no_ov", 32'(ov_cnt - ov_base), 0);
    check_eq("sim_ack_valid_kept", 32'(word_valid), 1);
    manual_ack("beef_ack_clears");

    // Reset in mid-frame: rest of the frame must produce nothing.
    frame_start();
    send_bits(32'h4321, W);
    frame_end();
    frame_start();
    send_bits(32'hAB, 8);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    check_eq("midrst_valid", 32'(word_valid), 0);
    check_eq("midrst_word", 32'(word_out), 0);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_state", 32'(dbg_state), 32'(SPI_IDLE));
    fe_base = fe_cnt;
    send_bits(32'hCD, 8);
    send_bits(32'h1357, W);
    frame_end();
    check_eq("midrst_no_word", 32'(word_valid), 0);
    check_eq("midrst_no_fe", 32'(fe_cnt - fe_base), 0);
    frame_start();
    send_bits(32'h8001, W);
    frame_end();
    check_eq("post_rst_word", 32'(word_out), 32'h8001);
    check_eq("post_rst_valid", 32'(word_valid), 1);
    manual_ack("post_rst_ack");

    // Random frames: 0..2 full words, some ending in a partial word.
    auto_mode = 1'b1;
    fe_base   = fe_cnt;
    ov_base   = ov_cnt;
    exp_fe    = 0;
    for (int f = 0; f < 20; f++) begin
      nw = $urandom_range(0, 2);
      frame_start();
      for (int j = 0; j < nw; j++) send_word(W'($urandom));
      if (nw == 0 || $urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, W - 1);
        send_bits($urandom, k);
        exp_fe++;
      end
      frame_end();
    end
    wait_clk(2 * HALF);
    check_eq("rand_q_empty", 32'(exp_q.size()), 0);
    check_eq("rand_handshakes", 32'(hs_cnt), 32'(pushed));
    check_eq("rand_frame_errs", 32'(fe_cnt - fe_base), 32'(exp_fe));
    check_eq("rand_no_ov", 32'(ov_cnt - ov_base), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
